// File: rtl/branch_resolver.sv
// Branch resolver: holds the SZCV flag register and resolves decode-stage branches to taken/target.
// Latency: result valid one cycle after the accept edge; at most one branch in flight (3-cycle minimum spacing).
// Backpressure: br_ready is low outside IDLE; the result is held stable until res_ready is seen.
module branch_resolver #(
  parameter int PC_W   = 16,
  parameter int DISP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flag_we,
  input  logic [3:0]        szcv_in,
  output logic [3:0]        flags,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [DISP_W-1:0] br_disp,
  input  logic [PC_W-1:0]   br_pc,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_taken,
  output logic [PC_W-1:0]   res_target,
  output logic              res_illegal
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;
  localparam logic [2:0] COND_B   = 3'b100;

  state_t            state_q, state_d;
  logic [2:0]        cond_q;
  logic [DISP_W-1:0] disp_q;
  logic [PC_W-1:0]   pc_q;

  logic [3:0]        eff_flags;
  logic              eff_s, eff_z, eff_v;
  logic              taken_c, illegal_c;
  logic [PC_W-1:0]   disp_ext, seq_pc, target_c;

  // An ALU write landing in the EVAL cycle is forwarded straight into the decision.
  assign eff_flags = flag_we ? szcv_in : flags;
  assign eff_s     = eff_flags[3];
  assign eff_z     = eff_flags[2];
  assign eff_v     = eff_flags[0];

  assign disp_ext  = {{(PC_W-DISP_W){disp_q[DISP_W-1]}}, disp_q};
  assign seq_pc    = pc_q + PC_W'(1);
  assign target_c  = taken_c ? (seq_pc + disp_ext) : seq_pc;

  always_comb begin
    taken_c   = 1'b0;
    illegal_c = 1'b0;
    case (cond_q)
      COND_BE:  taken_c = eff_z;
      COND_BLT: taken_c = eff_s ^ eff_v;
      COND_BLE: taken_c = eff_z | (eff_s ^ eff_v);
      COND_BNE: taken_c = ~eff_z;
      COND_B:   taken_c = 1'b1;
      default:  illegal_c = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    br_ready  = (state_q == IDLE);
    res_valid = (state_q == HOLD);
    case (state_q)
      IDLE:    if (br_valid) state_d = EVAL;
      EVAL:    state_d = HOLD;
      HOLD:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      flags       <= 4'b0000;
      cond_q      <= 3'b000;
      disp_q      <= '0;
      pc_q        <= '0;
      res_taken   <= 1'b0;
      res_target  <= '0;
      res_illegal <= 1'b0;
    end else begin
      state_q <= state_d;
      if (flag_we) flags <= szcv_in;
      if (state_q == IDLE && br_valid) begin
        cond_q <= br_cond;
        disp_q <= br_disp;
        pc_q   <= br_pc;
      end
      if (state_q == EVAL) begin
        res_taken   <= taken_c;
        res_target  <= target_c;
        res_illegal <= illegal_c;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: inputs change 1ns after each rising edge, outputs checked there too.
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_we;
  logic [3:0]  szcv_in;
  logic [3:0]  flags;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_cond;
  logic [7:0]  br_disp;
  logic [15:0] br_pc;
  logic        res_valid;
  logic        res_ready;
  logic        res_taken;
  logic [15:0] res_target;
  logic        res_illegal;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_resolver #(.PC_W(16), .DISP_W(8)) dut (
    .clk(clk), .rst(rst),
    .flag_we(flag_we), .szcv_in(szcv_in), .flags(flags),
    .br_valid(br_valid), .br_ready(br_ready), .br_cond(br_cond),
    .br_disp(br_disp), .br_pc(br_pc),
    .res_valid(res_valid), .res_ready(res_ready), .res_taken(res_taken),
    .res_target(res_target), .res_illegal(res_illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_flags(input logic [3:0] f);
    flag_we = 1'b1;
    szcv_in = f;
    tick();
    flag_we = 1'b0;
  endtask

  // Accept edge, then the EVAL edge; returns with the result held.
  task automatic issue(input logic [2:0] c, input logic [7:0] d, input logic [15:0] pc);
    br_valid = 1'b1;
    br_cond  = c;
    br_disp  = d;
    br_pc    = pc;
    tick();
    br_valid = 1'b0;
    tick();
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic t, input logic [15:0] tgt, input logic ill);
    chk({tag, "_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_taken"}, 32'(res_taken), 32'(t));
    chk({tag, "_target"}, 32'(res_target), 32'(tgt));
    chk({tag, "_illegal"}, 32'(res_illegal), 32'(ill));
  endtask

  initial begin
    rst = 1'b1; flag_we = 1'b0; szcv_in = 4'h0; br_valid = 1'b0;
    br_cond = 3'b000; br_disp = 8'h00; br_pc = 16'h0000; res_ready = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_br_ready", 32'(br_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_taken", 32'(res_taken), 32'd0);
    chk("rst_target", 32'(res_target), 32'h0);
    chk("rst_illegal", 32'(res_illegal), 32'd0);

    set_flags(4'b0100);
    chk("flag_write", 32'(flags), 32'h4);

    // BE with Z=1, then hold under backpressure.
    br_valid = 1'b1; br_cond = 3'b000; br_disp = 8'h05; br_pc = 16'h0010;
    tick();
    br_valid = 1'b0;
    chk("be_eval_ready", 32'(br_ready), 32'd0);
    chk("be_eval_valid", 32'(res_valid), 32'd0);
    tick();
    chk_res("be", 1'b1, 16'h0016, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_res("be_hold", 1'b1, 16'h0016, 1'b0);
    end
    // A new request and a flag write during HOLD must not disturb the result.
    br_valid = 1'b1; br_cond = 3'b011; br_pc = 16'h0999;
    flag_we = 1'b1; szcv_in = 4'b0000;
    tick();
    br_valid = 1'b0; flag_we = 1'b0;
    chk("hold_flags", 32'(flags), 32'h0);
    chk("hold_br_ready", 32'(br_ready), 32'd0);
    chk_res("be_hold_wr", 1'b1, 16'h0016, 1'b0);
    release_res();
    chk("be_rel_valid", 32'(res_valid), 32'd0);
    chk("be_rel_ready", 32'(br_ready), 32'd1);

    // Signed compare with negative displacement.
    set_flags(4'b1000);
    issue(3'b001, 8'hFE, 16'h0020);
    chk_res("blt_t", 1'b1, 16'h001F, 1'b0);
    release_res();
    set_flags(4'b1001);
    issue(3'b001, 8'hFE, 16'h0020);
    chk_res("blt_nt", 1'b0, 16'h0021, 1'b0);
    release_res();

    // BLE: V alone makes S^V true; all clear is not taken.
    set_flags(4'b0001);
    issue(3'b010, 8'h7F, 16'h0030);
    chk_res("ble_t", 1'b1, 16'h00B0, 1'b0);
    release_res();
    set_flags(4'b0000);
    issue(3'b010, 8'h7F, 16'h0030);
    chk_res("ble_nt", 1'b0, 16'h0031, 1'b0);
    release_res();

    // Forwarding: Z written in the EVAL cycle turns BNE into not-taken.
    br_valid = 1'b1; br_cond = 3'b011; br_disp = 8'h10; br_pc = 16'h0100;
    tick();
    br_valid = 1'b0;
    flag_we = 1'b1; szcv_in = 4'b0100;
    tick();
    flag_we = 1'b0;
    chk_res("fwd_bne", 1'b0, 16'h0101, 1'b0);
    chk("fwd_flags", 32'(flags), 32'h4);
    release_res();

    issue(3'b100, 8'h00, 16'hFFFF);
    chk_res("b_wrap", 1'b1, 16'h0000, 1'b0);
    release_res();

    issue(3'b110, 8'h10, 16'h1234);
    chk_res("illegal", 1'b0, 16'h1235, 1'b1);
    release_res();

    // Reset while a result is held drops it.
    set_flags(4'b1111);
    issue(3'b100, 8'h03, 16'h0040);
    chk_res("pre_rst", 1'b1, 16'h0044, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hrst_valid", 32'(res_valid), 32'd0);
    chk("hrst_flags", 32'(flags), 32'h0);
    chk("hrst_ready", 32'(br_ready), 32'd1);
    chk("hrst_target", 32'(res_target), 32'h0);
    res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hrst_no_result", 32'(res_valid), 32'd0);
    end
    res_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
